// File: rtl/a78_pkg.sv
// Shared types and constants for the A78 cartridge loader: FSM states, header layout, magic.
package a78_pkg;

    localparam int HDR_LEN   = 128;
    localparam int PROBE_LEN = 6;

    localparam logic [39:0] MAGIC = "ATARI";

    localparam int SIZE_B0  = 49;
    localparam int FLAGS_HI = 53;
    localparam int FLAGS_LO = 54;
    localparam int REGION   = 57;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_REPLAY,
        ST_HEADER,
        ST_BODY,
        ST_DONE
    } state_e;

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/a78_cart_loader_if.sv
// Download stream in, cart RAM write port out. master = HPS/RAM side, slave = loader.
interface a78_cart_loader_if #(
    parameter int ADDR_W = 18
);
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic              cart_we;
    logic [ADDR_W-1:0] cart_waddr;
    logic [7:0]        cart_wdata;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  cart_we, cart_waddr, cart_wdata
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output cart_we, cart_waddr, cart_wdata
    );
endinterface

// File: rtl/a78_probe_buf.sv
// Holds the first six file bytes until the header decision, then replays a given count of them.
// Emit is one byte per cycle from the cycle after start; no backpressure.
module a78_probe_buf
    import a78_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       wr_en_i,
    input  logic [2:0] wr_idx_i,
    input  logic [7:0] wr_dat_i,
    input  logic       start_i,
    input  logic [2:0] start_cnt_i,
    output logic [2:0] fill_cnt_o,
    output logic       magic_o,
    output logic       emit_vld_o,
    output logic [2:0] emit_addr_o,
    output logic [7:0] emit_dat_o,
    output logic       emit_last_o
);

    logic [PROBE_LEN-1:0][7:0] buf_q, buf_d;
    logic [2:0]                fill_q, fill_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [2:0]                rp_q, rp_d;
    logic                      act_q, act_d;

    // Magic is judged on the offset-5 write itself, so the last letter comes from the bus.
    assign magic_o     = ({buf_q[1], buf_q[2], buf_q[3], buf_q[4], wr_dat_i} == MAGIC);
    assign fill_cnt_o  = fill_q;
    assign emit_vld_o  = act_q;
    assign emit_addr_o = rp_q;
    assign emit_dat_o  = buf_q[rp_q];
    assign emit_last_o = act_q && (rp_q == cnt_q - 3'd1);

    always_comb begin
        buf_d  = buf_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        rp_d   = rp_q;
        act_d  = act_q;
        if (clr_i) begin
            buf_d  = '0;
            fill_d = '0;
            cnt_d  = '0;
            rp_d   = '0;
            act_d  = 1'b0;
        end else begin
            if (wr_en_i && (wr_idx_i < 3'(PROBE_LEN))) begin
                buf_d[wr_idx_i] = wr_dat_i;
                if (fill_q != 3'(PROBE_LEN)) begin
                    fill_d = fill_q + 3'd1;
                end
            end
            if (start_i) begin
                act_d = (start_cnt_i != 3'd0);
                rp_d  = '0;
                cnt_d = start_cnt_i;
            end else if (act_q) begin
                if (emit_last_o) begin
                    act_d = 1'b0;
                end else begin
                    rp_d = rp_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            buf_q  <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            rp_q   <= '0;
            act_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            rp_q   <= rp_d;
            act_q  <= act_d;
        end
    end

endmodule

// File: rtl/a78_cart_loader.sv
// Strips the A78 header from cart downloads, latches cart info, streams body bytes to cart RAM.
// RAM writes one cycle after the ioctl strobe; no backpressure. A78_SIZE_CHECK_EN adds size_mismatch.
module a78_cart_loader
    import a78_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic               clk_sys,
    input  logic               reset,
    a78_cart_loader_if.slave   bus,
    output logic               cart_is_7800,
    output logic [15:0]        cart_flags,
    output logic               cart_region,
    output logic [31:0]        cart_size,
    output logic               loading,
    output logic               load_done
`ifdef A78_SIZE_CHECK_EN
    ,
    output logic               size_mismatch
`endif
);

    localparam logic [31:0] HDR32 = 32'(HDR_LEN);

    state_e            state_q, state_d;
    logic              cart_dl_q;
    logic              end_q, end_d;
    logic              start_pend_q, start_pend_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              is7800_q, is7800_d;
    logic [15:0]       flags_q, flags_d;
    logic              region_q, region_d;
    logic [31:0]       size_q, size_d;
    logic              loading_q, loading_d;
    logic              done_q, done_d;
    logic              skid_vld_q, skid_vld_d;
    logic [24:0]       skid_addr_q, skid_addr_d;
    logic [7:0]        skid_dat_q, skid_dat_d;
    logic [24:0]       last_off_q, last_off_d;
    logic              any_wr_q, any_wr_d;
`ifdef A78_SIZE_CHECK_EN
    logic [31:0]       decl_q, decl_d;
    logic              mism_q, mism_d;
`endif

    logic        cart_dl, rise, fall, wr_ok, in_load;
    logic        pb_clr, pb_wr, pb_start, pb_magic;
    logic [2:0]  pb_cnt, pb_fill;
    logic        emit_vld, emit_last;
    logic [2:0]  emit_addr;
    logic [7:0]  emit_dat;
    logic        body_vld;
    logic [24:0] body_off;
    logic [7:0]  body_dat;
    logic [31:0] body_sub, size_calc;

    assign cart_dl = bus.ioctl_download & (bus.ioctl_index != 8'd0);
    assign wr_ok   = bus.ioctl_wr & (bus.ioctl_index != 8'd0);
    assign rise    = cart_dl & ~cart_dl_q;
    assign fall    = ~cart_dl & cart_dl_q;
    assign in_load = (state_q == ST_PROBE) || (state_q == ST_REPLAY) ||
                     (state_q == ST_HEADER) || (state_q == ST_BODY);

    assign size_calc = sat_sub(any_wr_q ? ({7'd0, last_off_q} + 32'd1) : 32'd0,
                               is7800_q ? HDR32 : 32'd0);

    a78_probe_buf u_probe (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .clr_i       (pb_clr),
        .wr_en_i     (pb_wr),
        .wr_idx_i    (bus.ioctl_addr[2:0]),
        .wr_dat_i    (bus.ioctl_dout),
        .start_i     (pb_start),
        .start_cnt_i (pb_cnt),
        .fill_cnt_o  (pb_fill),
        .magic_o     (pb_magic),
        .emit_vld_o  (emit_vld),
        .emit_addr_o (emit_addr),
        .emit_dat_o  (emit_dat),
        .emit_last_o (emit_last)
    );

    always_comb begin
        state_d      = state_q;
        end_d        = end_q;
        start_pend_d = start_pend_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        is7800_d     = is7800_q;
        flags_d      = flags_q;
        region_d     = region_q;
        size_d       = size_q;
        loading_d    = loading_q;
        done_d       = 1'b0;
        skid_vld_d   = skid_vld_q;
        skid_addr_d  = skid_addr_q;
        skid_dat_d   = skid_dat_q;
        last_off_d   = last_off_q;
        any_wr_d     = any_wr_q;
`ifdef A78_SIZE_CHECK_EN
        decl_d       = decl_q;
        mism_d       = mism_q;
`endif
        pb_clr       = 1'b0;
        pb_wr        = 1'b0;
        pb_start     = 1'b0;
        pb_cnt       = pb_fill;
        body_vld     = 1'b0;
        body_off     = bus.ioctl_addr;
        body_dat     = bus.ioctl_dout;
        body_sub     = '0;

        if (in_load && wr_ok) begin
            last_off_d = bus.ioctl_addr;
            any_wr_d   = 1'b1;
        end
        // A falling edge is acted on one cycle later so a coincident last byte lands first.
        if (in_load && fall) begin
            end_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise || start_pend_q) begin
                    state_d      = ST_PROBE;
                    start_pend_d = 1'b0;
                    end_d        = 1'b0;
                    is7800_d     = 1'b0;
                    flags_d      = '0;
                    region_d     = 1'b0;
                    size_d       = '0;
                    loading_d    = 1'b1;
                    skid_vld_d   = 1'b0;
                    last_off_d   = '0;
                    any_wr_d     = 1'b0;
                    pb_clr       = 1'b1;
`ifdef A78_SIZE_CHECK_EN
                    decl_d       = '0;
                    mism_d       = 1'b0;
`endif
                end
            end
            ST_PROBE: begin
                if (end_q) begin
                    if (pb_fill == 3'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        pb_start = 1'b1;
                        state_d  = ST_REPLAY;
                    end
                end else if (wr_ok) begin
                    pb_wr = (bus.ioctl_addr < 25'(PROBE_LEN));
                    if (bus.ioctl_addr == 25'(PROBE_LEN - 1)) begin
                        if (pb_magic) begin
                            is7800_d = 1'b1;
                            state_d  = ST_HEADER;
                        end else begin
                            pb_start = 1'b1;
                            pb_cnt   = 3'(PROBE_LEN);
                            state_d  = ST_REPLAY;
                        end
                    end
                end
            end
            ST_REPLAY: begin
                we_d    = emit_vld;
                waddr_d = ADDR_W'(emit_addr);
                wdata_d = emit_dat;
                if (wr_ok) begin
                    skid_vld_d  = 1'b1;
                    skid_addr_d = bus.ioctl_addr;
                    skid_dat_d  = bus.ioctl_dout;
                end
                if (emit_last) begin
                    state_d = end_d ? ST_DONE : ST_BODY;
                end
            end
            ST_HEADER: begin
                if (end_q) begin
                    state_d = ST_DONE;
                end else if (wr_ok && (bus.ioctl_addr < 25'(HDR_LEN))) begin
                    if (bus.ioctl_addr == 25'(FLAGS_HI)) flags_d[15:8] = bus.ioctl_dout;
                    if (bus.ioctl_addr == 25'(FLAGS_LO)) flags_d[7:0]  = bus.ioctl_dout;
                    if (bus.ioctl_addr == 25'(REGION))   region_d      = bus.ioctl_dout[0];
`ifdef A78_SIZE_CHECK_EN
                    if (bus.ioctl_addr == 25'(SIZE_B0))     decl_d[31:24] = bus.ioctl_dout;
                    if (bus.ioctl_addr == 25'(SIZE_B0 + 1)) decl_d[23:16] = bus.ioctl_dout;
                    if (bus.ioctl_addr == 25'(SIZE_B0 + 2)) decl_d[15:8]  = bus.ioctl_dout;
                    if (bus.ioctl_addr == 25'(SIZE_B0 + 3)) decl_d[7:0]   = bus.ioctl_dout;
`endif
                    if (bus.ioctl_addr == 25'(HDR_LEN - 1)) begin
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (skid_vld_q) begin
                    body_vld   = 1'b1;
                    body_off   = skid_addr_q;
                    body_dat   = skid_dat_q;
                    skid_vld_d = 1'b0;
                end else if (wr_ok) begin
                    body_vld = 1'b1;
                end
                // Offsets that land past the RAM (or below the header) wrap high and are dropped.
                body_sub = {7'd0, body_off} - (is7800_q ? HDR32 : 32'd0);
                if (body_vld) begin
                    we_d    = (body_sub[31:ADDR_W] == '0);
                    waddr_d = body_sub[ADDR_W-1:0];
                    wdata_d = body_dat;
                end
                if (end_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                size_d    = size_calc;
                done_d    = 1'b1;
                loading_d = 1'b0;
                end_d     = 1'b0;
                state_d   = ST_IDLE;
                if (rise) begin
                    start_pend_d = 1'b1;
                end
`ifdef A78_SIZE_CHECK_EN
                mism_d = is7800_q && (decl_q != size_calc);
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cart_dl_q    <= 1'b0;
            end_q        <= 1'b0;
            start_pend_q <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            is7800_q     <= 1'b0;
            flags_q      <= '0;
            region_q     <= 1'b0;
            size_q       <= '0;
            loading_q    <= 1'b0;
            done_q       <= 1'b0;
            skid_vld_q   <= 1'b0;
            skid_addr_q  <= '0;
            skid_dat_q   <= '0;
            last_off_q   <= '0;
            any_wr_q     <= 1'b0;
`ifdef A78_SIZE_CHECK_EN
            decl_q       <= '0;
            mism_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cart_dl_q    <= cart_dl;
            end_q        <= end_d;
            start_pend_q <= start_pend_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            is7800_q     <= is7800_d;
            flags_q      <= flags_d;
            region_q     <= region_d;
            size_q       <= size_d;
            loading_q    <= loading_d;
            done_q       <= done_d;
            skid_vld_q   <= skid_vld_d;
            skid_addr_q  <= skid_addr_d;
            skid_dat_q   <= skid_dat_d;
            last_off_q   <= last_off_d;
            any_wr_q     <= any_wr_d;
`ifdef A78_SIZE_CHECK_EN
            decl_q       <= decl_d;
            mism_q       <= mism_d;
`endif
        end
    end

    assign bus.cart_we    = we_q;
    assign bus.cart_waddr = waddr_q;
    assign bus.cart_wdata = wdata_q;
    assign cart_is_7800   = is7800_q;
    assign cart_flags     = flags_q;
    assign cart_region    = region_q;
    assign cart_size      = size_q;
    assign loading        = loading_q;
    assign load_done      = done_q;
`ifdef A78_SIZE_CHECK_EN
    assign size_mismatch  = mism_q;
`endif

endmodule
